// File: rtl/ro_freq_counter.sv
// ro_freq_counter: gated rising-edge counter for an asynchronous ring-oscillator input.
// A three-flop synchronizer feeds an edge detector that is counted over a window of N clocks.
module ro_freq_counter #(
  parameter int CNT_BITS  = 16,
  parameter int GATE_BITS = 24
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
  input  logic                 osc_in,
  input  logic                 start,
  input  logic [GATE_BITS-1:0] gate_cycles,
  output logic [CNT_BITS-1:0]  count,
  output logic                 busy,
  output logic                 valid,
  output logic                 overflow
);
  typedef enum logic {IDLE, COUNT} state_t;
  state_t               r_state, w_next;
  logic                 r_sync1, r_sync2, r_sync3;
  logic [GATE_BITS-1:0] r_timer;
  logic [CNT_BITS-1:0]  r_count;
  logic                 r_valid, r_overflow;
  logic                 w_edge, w_accept, w_last, w_sat;
  assign w_edge   = r_sync2 & ~r_sync3;
  assign w_accept = (r_state == IDLE) && start;
  assign w_last   = (r_state == COUNT) && (r_timer == GATE_BITS'(1));
  assign w_sat    = &r_count;
  assign count    = r_count;
  assign busy     = r_state == COUNT;
  assign valid    = r_valid;
  assign overflow = r_overflow;
  always_comb begin
    w_next = r_state;
    w_next = (w_accept && gate_cycles != '0) ? COUNT : w_last ? IDLE : r_state;
  end
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) r_state <= IDLE;
    else          r_state <= w_next;
  end
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_sync3 <= 1'b0;
    end else begin
      r_sync1 <= osc_in;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
    end
  end
  // A zero-length window completes on the accepting edge itself.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_timer    <= '0;
      r_count    <= '0;
      r_valid    <= 1'b0;
      r_overflow <= 1'b0;
    end else if (w_accept) begin
      r_timer    <= gate_cycles;
      r_count    <= '0;
      r_overflow <= 1'b0;
      r_valid    <= gate_cycles == '0;
    end else if (r_state == COUNT) begin
      r_timer <= r_timer - GATE_BITS'(1);
      if (w_last) r_valid <= 1'b1;
      if (w_edge) begin
        if (w_sat) r_overflow <= 1'b1;
        else       r_count    <= r_count + CNT_BITS'(1);
      end
    end
  end
endmodule

// File: tb/tb_ro_freq_counter.sv
// tb_ro_freq_counter: directed stimulus with a queue scoreboard checked on each valid rise.
module tb_ro_freq_counter;
  logic        clk = 1'b0, rst = 1'b1, osc = 1'b0, start = 1'b0, start4 = 1'b0;
  logic [23:0] gate = '0;
  logic [15:0] count;
  logic        busy, valid, overflow;
  logic [3:0]  count4;
  logic        busy4, valid4, ovf4;
  logic        pv = 1'b0, pv4 = 1'b0;
  int          errors = 0, checks = 0, ncyc = 0, mode = 0, div = 0;
  typedef struct {int cnt; int ovf; int cyc;} exp_t;
  exp_t        q[$], q4[$];

  ro_freq_counter #(.CNT_BITS(16), .GATE_BITS(24)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .osc_in(osc), .start(start), .gate_cycles(gate),
    .count(count), .busy(busy), .valid(valid), .overflow(overflow));

  ro_freq_counter #(.CNT_BITS(4), .GATE_BITS(24)) dut4 (
    .wb_clk_i(clk), .wb_rst_i(rst), .osc_in(osc), .start(start4), .gate_cycles(gate),
    .count(count4), .busy(busy4), .valid(valid4), .overflow(ovf4));

  always #5 clk = ~clk;
  always @(posedge clk) ncyc <= ncyc + 1;
  // mode 0: constant low, 1: constant high, 2: square wave of period 4 clocks
  always @(negedge clk) begin
    div <= div + 1;
    osc <= (mode == 2) ? div[1] : (mode == 1);
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    pv <= valid;
    if (valid && !pv) begin
      if (q.size() == 0) chk("unexpected_valid", 1, 0);
      else begin
        chk("count", count, q[0].cnt);
        chk("overflow", overflow, q[0].ovf);
        chk("valid_cycle", ncyc, q[0].cyc);
        chk("busy_at_valid", busy, 0);
        void'(q.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    pv4 <= valid4;
    if (valid4 && !pv4) begin
      if (q4.size() == 0) chk("unexpected_valid4", 1, 0);
      else begin
        chk("count4", count4, q4[0].cnt);
        chk("overflow4", ovf4, q4[0].ovf);
        chk("valid4_cycle", ncyc, q4[0].cyc);
        chk("busy4_at_valid", busy4, 0);
        void'(q4.pop_front());
      end
    end
  end

  // Called at a falling edge; the following rising edge samples start (edge 0).
  task automatic issue(input int n, input int cnt, input int ovf, input bit push, input bit use4);
    exp_t x;
    gate = 24'(n);
    if (use4) start4 = 1'b1;
    else      start  = 1'b1;
    x = '{cnt, ovf, ncyc + 1 + n};
    if (push && use4)  q4.push_back(x);
    if (push && !use4) q.push_back(x);
    @(negedge clk);
    start  = 1'b0;
    start4 = 1'b0;
  endtask

  task automatic wait_valid(input bit use4);
    for (int i = 0; i < 300 && !(use4 ? valid4 : valid); i++) @(negedge clk);
    chk("valid_wait", use4 ? valid4 : valid, 1);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_count", count, 0);
    chk("rst_busy", busy, 0);
    chk("rst_valid", valid, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_valid4", valid4, 0);
    rst = 1'b0;
    mode = 2;
    repeat (10) @(negedge clk);
    issue(0, 0, 0, 1, 0);
    chk("gate0_busy", busy, 0);
    chk("gate0_valid", valid, 1);
    chk("gate0_count", count, 0);
    repeat (3) @(negedge clk);
    chk("gate0_busy_later", busy, 0);
    issue(100, 25, 0, 1, 0);
    chk("busy_running", busy, 1);
    wait_valid(0);
    repeat (3) @(negedge clk);
    chk("count_hold", count, 25);
    repeat (2) @(negedge clk);
    issue(100, 25, 0, 1, 0);
    wait_valid(0);
    mode = 0;
    repeat (8) @(negedge clk);
    issue(50, 0, 0, 1, 0);
    wait_valid(0);
    mode = 1;
    repeat (8) @(negedge clk);
    issue(50, 0, 0, 1, 0);
    wait_valid(0);
    mode = 2;
    repeat (8) @(negedge clk);
    issue(100, 25, 0, 1, 0);
    repeat (9) @(negedge clk);
    gate = 24'd7;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (49) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_ignored_start", busy, 1);
    wait_valid(0);
    issue(40, 10, 0, 1, 0);
    chk("valid_dropped", valid, 0);
    wait_valid(0);
    repeat (4) @(negedge clk);
    issue(100, 15, 1, 1, 1);
    wait_valid(1);
    repeat (4) @(negedge clk);
    issue(100, 0, 0, 0, 0);
    repeat (29) @(negedge clk);
    chk("busy_before_abort", busy, 1);
    #2 rst = 1'b1;
    #1;
    chk("abort_count", count, 0);
    chk("abort_busy", busy, 0);
    chk("abort_valid", valid, 0);
    chk("abort_overflow", overflow, 0);
    chk("abort_count4", count4, 0);
    chk("abort_overflow4", ovf4, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("post_abort_valid", valid, 0);
    chk("post_abort_busy", busy, 0);
    for (int i = 0; i < 50 && (q.size() + q4.size()) != 0; i++) @(negedge clk);
    chk("queue_drained", q.size() + q4.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
